// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared types and constants for the basic_gates self-test
// sequencer.
//   sweep_state_t     - sequencer FSM states
//   RES_W / NUM_VEC   - width of one gate-result word / number of (a,b) vectors
//   EXP_TABLE_DEFAULT - golden {p,w3,w2,z,w1,y} per vector, vector i in [6i+5:6i]
//   exp_slice()       - extracts the golden word of one vector from a table
package gate_sweep_pkg;

    localparam int RES_W   = 6;
    localparam int NUM_VEC = 4;
    localparam int IDX_W   = 2;

    // y=AND, w1=OR, z=NOT a, w2=NAND, w3=NOR, p=XOR for (a,b)=00,01,10,11
    localparam logic [RES_W*NUM_VEC-1:0] EXP_TABLE_DEFAULT = 24'h0EAB9C;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SAMPLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } sweep_state_t;

    function automatic logic [RES_W-1:0] exp_slice(
        input logic [RES_W*NUM_VEC-1:0] tbl,
        input logic [IDX_W-1:0]         idx
    );
        return tbl[int'(idx)*RES_W +: RES_W];
    endfunction

endpackage

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: clocked self-test sequencer for basic_gates. On start it
// walks (a,b) through 00,01,10,11, holds each vector HOLD_CYCLES cycles,
// samples the six gate outputs and compares them with a golden table.
// Ports:
//   clk, rst_n       - clock (rising edge), asynchronous active-low reset
//   start, abort     - launch a sweep (idle/done only); abandon a sweep
//   res[5:0]         - {p,w3,w2,z,w1,y} returned by basic_gates
//   gate_a, gate_b   - vector driven into basic_gates
//   busy, done, pass - progress and overall verdict (pass valid with done)
//   fail_mask[3:0]   - bit i set when vector i mismatched
//   first_fail_idx   - lowest failing vector index (0 when none failed)
//   last_capture     - most recently sampled res
// All outputs are registered.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int                         HOLD_CYCLES = 2,
    parameter logic [RES_W*NUM_VEC-1:0]   EXP_TABLE   = EXP_TABLE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [RES_W-1:0] res,
    output logic             gate_a,
    output logic             gate_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       fail_mask,
    output logic [1:0]       first_fail_idx,
    output logic [RES_W-1:0] last_capture
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    sweep_state_t      state_r, state_n;
    logic [IDX_W-1:0]  idx_r, idx_n, idx_inc_s;
    logic [HOLD_W-1:0] hold_r, hold_n;
    logic              gate_a_r, gate_a_n, gate_b_r, gate_b_n;
    logic              busy_r, busy_n, done_r, done_n, pass_r, pass_n;
    logic [3:0]        fail_mask_r, fail_mask_n, mask_upd_s;
    logic [1:0]        first_fail_r, first_fail_n;
    logic [RES_W-1:0]  last_capture_r, last_capture_n;
    logic              mismatch_s;

    // Next-state and next-output logic for the sweep FSM
    always_comb begin
        state_n        = state_r;
        idx_n          = idx_r;
        hold_n         = hold_r;
        gate_a_n       = gate_a_r;
        gate_b_n       = gate_b_r;
        busy_n         = busy_r;
        done_n         = done_r;
        pass_n         = pass_r;
        fail_mask_n    = fail_mask_r;
        first_fail_n   = first_fail_r;
        last_capture_n = last_capture_r;
        idx_inc_s      = idx_r + 2'd1;
        mismatch_s     = (last_capture_r != exp_slice(EXP_TABLE, idx_r));
        // Mask as it will look once the current vector's verdict is folded in
        mask_upd_s     = fail_mask_r | (mismatch_s ? (4'b0001 << idx_r) : 4'b0000);

        if (abort) begin
            // Partial fail_mask / last_capture are kept for post-mortem
            state_n  = IDLE;
            busy_n   = 1'b0;
            done_n   = 1'b0;
            pass_n   = 1'b0;
            gate_a_n = 1'b0;
            gate_b_n = 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        state_n      = DRIVE;
                        idx_n        = 2'd0;
                        hold_n       = '0;
                        gate_a_n     = 1'b0;
                        gate_b_n     = 1'b0;
                        busy_n       = 1'b1;
                        done_n       = 1'b0;
                        pass_n       = 1'b0;
                        fail_mask_n  = 4'b0000;
                        first_fail_n = 2'd0;
                    end else begin
                        state_n = state_r;
                    end
                end
                DRIVE: begin
                    if (hold_r == HOLD_LAST) begin
                        state_n = SAMPLE;
                    end else begin
                        hold_n = hold_r + HOLD_W'(1);
                    end
                end
                SAMPLE: begin
                    last_capture_n = res;
                    state_n        = CHECK;
                end
                CHECK: begin
                    fail_mask_n = mask_upd_s;
                    // First failure of the sweep: nothing recorded yet
                    if (mismatch_s && (fail_mask_r == 4'b0000)) begin
                        first_fail_n = idx_r;
                    end else begin
                        first_fail_n = first_fail_r;
                    end
                    if (idx_r == 2'd3) begin
                        state_n  = DONE;
                        busy_n   = 1'b0;
                        done_n   = 1'b1;
                        pass_n   = (mask_upd_s == 4'b0000);
                        gate_a_n = 1'b0;
                        gate_b_n = 1'b0;
                    end else begin
                        state_n  = DRIVE;
                        idx_n    = idx_inc_s;
                        hold_n   = '0;
                        gate_a_n = idx_inc_s[1];
                        gate_b_n = idx_inc_s[0];
                    end
                end
                default: begin
                    state_n  = IDLE;
                    busy_n   = 1'b0;
                    done_n   = 1'b0;
                    pass_n   = 1'b0;
                    gate_a_n = 1'b0;
                    gate_b_n = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            idx_r          <= 2'd0;
            hold_r         <= '0;
            gate_a_r       <= 1'b0;
            gate_b_r       <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            pass_r         <= 1'b0;
            fail_mask_r    <= 4'b0000;
            first_fail_r   <= 2'd0;
            last_capture_r <= 6'd0;
        end else begin
            state_r        <= state_n;
            idx_r          <= idx_n;
            hold_r         <= hold_n;
            gate_a_r       <= gate_a_n;
            gate_b_r       <= gate_b_n;
            busy_r         <= busy_n;
            done_r         <= done_n;
            pass_r         <= pass_n;
            fail_mask_r    <= fail_mask_n;
            first_fail_r   <= first_fail_n;
            last_capture_r <= last_capture_n;
        end
    end

    assign gate_a         = gate_a_r;
    assign gate_b         = gate_b_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign fail_mask      = fail_mask_r;
    assign first_fail_idx = first_fail_r;
    assign last_capture   = last_capture_r;

endmodule
